mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: MDU_CTRL

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 Start  input  1  one-cycle pulse from E stage; launches operation selected by MDUOp.
REQ-004 MDUOp  input  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 0 and 7 = no-op.
REQ-005 SrcA  input  32  first operand (rs), forwarded value.
REQ-006 SrcB  input  32  second operand (rt), forwarded value.
REQ-007 UseMD_D  input  1  D-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 Busy  output  1  multi-cycle operation in flight.
REQ-009 Stall  output  1  request to freeze F/D and bubble E.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 States: IDLE, RUN; Busy SHALL equal (state==RUN).
REQ-013 IDLE->RUN on Start with MDUOp in 1..4; counter loaded with MULT_LAT=5 (ops 1,2) or DIV_LAT=10 (ops 3,4).
REQ-014 Operands and op SHALL be latched at the Start edge; later SrcA/SrcB changes SHALL not affect the result.
REQ-015 RUN: counter decrements each cycle; on the edge where counter==1, HI/LO are written and state returns to IDLE.
REQ-016 Latency: with Start sampled at edge t, Busy is high for cycles t+1..t+N and HI/LO hold new values from cycle t+N+1 (N=5 or 10).
REQ-017 MULT: {HI,LO}=signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-018 DIV: LO=signed quotient truncated toward zero, HI=remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-019 Divisor 0: full DIV_LAT busy period SHALL elapse and HI/LO SHALL remain unchanged.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
REQ-021 MTHI/MTLO (ops 5,6) with Start in IDLE: HI or LO written with SrcA at that edge; single cycle, Busy stays low.
REQ-022 Start while RUN, or with op 0/7: ignored; no state or register change.
REQ-023 Stall SHALL be combinational: UseMD_D & (Busy | Start).
REQ-024 HI/LO SHALL change only per REQ-015, REQ-021 or reset.

Reset
REQ-025 reset high SHALL immediately force state=IDLE, counter=0, Busy=0, Stall driven only by UseMD_D&Start, HI=0, LO=0, latched operands=0.
REQ-026 reset during RUN SHALL abort the operation; no HI/LO write after reset release.
REQ-027 First Start after reset release SHALL behave as from IDLE.

Structure
REQ-028 A shared package SHALL hold the MDUOp encodings, MULT_LAT, DIV_LAT and the state encoding; the E-stage decoder uses the same package.
REQ-029 One sub-module MDU_CALC (combinational 64-bit multiply/divide on latched operands) is natural; MDU_CTRL owns state, counter, HI/LO.
REQ-030 Counter width SHALL be 4 bits.

Verification
REQ-031 MULT SrcA=0xFFFFFFFE(-2), SrcB=3 -> Busy 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at t+6.
REQ-032 MULTU SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
REQ-033 DIV SrcA=-7, SrcB=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/0 -> HI/LO unchanged after 10 busy cycles.
REQ-034 UseMD_D=1 during DIV busy window -> Stall high every cycle t..t+10, low at t+11; second Start at t+3 ignored.
REQ-035 MTHI SrcA=0x12345678 in IDLE -> HI=0x12345678 next cycle, Busy never asserted.
REQ-036 reset asserted at t+3 of MULT -> Busy, HI, LO =0 immediately; remain 0 after release with no Start.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module : mdu_ctrl_pkg
// Brief  : Shared MDUOp encodings, latencies and state encoding for the MDU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic [3:0] op_latency(input logic [2:0] op);
        return ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LAT : DIV_LAT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_calc.sv
// ============================================================================
// Module : mdu_ctrl_calc
// Brief  : Combinational 64-bit multiply / 32-bit divide on latched operands.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_wr_en
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Sign-extended operands give the signed product modulo 2^64.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Sign-magnitude division: 0x80000000 / -1 wraps to 0x80000000 without a trap.
    assign w_a_neg   = (i_op == OP_DIV) && i_a[31];
    assign w_b_neg   = (i_op == OP_DIV) && i_b[31];
    assign w_mag_a   = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_mag_b   = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag   = w_mag_a / w_divisor;
    assign w_r_mag   = w_mag_a % w_divisor;
    assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_hi    = 32'd0;
        o_lo    = 32'd0;
        o_wr_en = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_hi    = w_prod_s[63:32];
                o_lo    = w_prod_s[31:0];
                o_wr_en = 1'b1;
            end
            OP_MULTU: begin
                o_hi    = w_prod_u[63:32];
                o_lo    = w_prod_u[31:0];
                o_wr_en = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_hi    = w_rem;
                o_lo    = w_quot;
                o_wr_en = (i_b != 32'd0);
            end
            default: begin
                o_wr_en = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module : mdu_ctrl
// Brief  : Multi-cycle multiply/divide controller owning HI/LO and stall.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        UseMD_D,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_calc_hi;
    logic [31:0] w_calc_lo;
    logic        w_calc_wr;

    mdu_ctrl_calc u_calc (
        .i_op    (r_op),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_hi    (w_calc_hi),
        .o_lo    (w_calc_lo),
        .o_wr_en (w_calc_wr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    if (is_long_op(MDUOp)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = op_latency(MDUOp);
                        w_latch     = 1'b1;
                    end else if (MDUOp == OP_MTHI) begin
                        w_hi_nxt = SrcA;
                    end else if (MDUOp == OP_MTLO) begin
                        w_lo_nxt = SrcA;
                    end
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // Final busy cycle: commit result (suppressed on divide-by-zero).
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    if (w_calc_wr) begin
                        w_hi_nxt = w_calc_hi;
                        w_lo_nxt = w_calc_lo;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= OP_NOP;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_latch) begin
                r_op <= MDUOp;
                r_a  <= SrcA;
                r_b  <= SrcB;
            end
        end
    end

    assign Busy  = (r_state == ST_RUN);
    assign Stall = UseMD_D & (Busy | Start);
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module : tb_mdu_ctrl
// Brief  : Self-checking bench: vector table, scoreboard and corner sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        UseMD_D;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDUOp   (MDUOp),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .UseMD_D (UseMD_D),
        .Busy    (Busy),
        .Stall   (Stall),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t        tbl [12];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi,
                                   input logic [31:0] lo);
        exp_t   e;
        longint sa, sbv, q, r;
        logic [63:0] p;
        e.hi = hi; e.lo = lo; e.lat = 0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 5; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 5; end
            OP_DIV: begin
                e.lat = 10;
                if (b != 0) begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            OP_DIVU: begin
                e.lat = 10;
                if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            end
            OP_MTHI: e.hi = a;
            OP_MTLO: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    // Launch one op, scramble operands afterwards, then compare against the scoreboard head.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        int   n;
        exp_t got;
        @(negedge clk);
        MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        SrcA  = $urandom;
        SrcB  = $urandom;
        MDUOp = 3'($urandom_range(0, 7));
        n = 0;
        while (Busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        got = sb.pop_front();
        chk({nm, "_lat"}, 32'(n), 32'(got.lat));
        chk({nm, "_hi"}, HI, got.hi);
        chk({nm, "_lo"}, LO, got.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = OP_NOP; SrcA = '0; SrcB = '0; UseMD_D = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        UseMD_D = 1'b1;
        #1;
        chk("rst_stall", 32'(Stall), 32'd0);
        UseMD_D = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{OP_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tbl[5]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0};
        tbl[6]  = '{OP_MTLO,  32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
        tbl[7]  = '{OP_NOP,   32'hDEADBEEF, 32'h1,        32'h12345678, 32'hCAFEF00D, 0};
        tbl[8]  = '{3'd7,     32'hDEADBEEF, 32'h1,        32'h12345678, 32'hCAFEF00D, 0};
        tbl[9]  = '{OP_DIVU,  32'h100,      32'h7,        32'h00000004, 32'h00000024, 10};
        tbl[10] = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        tbl[11] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.lat = tbl[i].lat;
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e);
        end

        // Stall window across a DIV, with a second Start mid-flight that must be ignored.
        @(negedge clk);
        UseMD_D = 1'b1; MDUOp = OP_DIV; SrcA = 32'd100; SrcB = 32'd10; Start = 1'b1;
        #1;
        chk("stall_t0", 32'(Stall), 32'd1);
        @(negedge clk);
        Start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("stall_t%0d", k), 32'(Stall), 32'd1);
            chk($sformatf("busy_t%0d", k), 32'(Busy), 32'd1);
            if (k == 3) begin
                Start = 1'b1; MDUOp = OP_MULT; SrcA = 32'd5; SrcB = 32'd5;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        chk("stall_t11", 32'(Stall), 32'd0);
        chk("busy_t11", 32'(Busy), 32'd0);
        chk("stall_div_hi", HI, 32'd0);
        chk("stall_div_lo", LO, 32'd10);
        UseMD_D = 1'b0;
        m_hi = 32'd0; m_lo = 32'd10;

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            exp_t        e;
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = (i == 4) ? 32'd0 : $urandom;
            e  = model(op, a, b, m_hi, m_lo);
            run_op($sformatf("rnd%0d", i), op, a, b, e);
            m_hi = e.hi; m_lo = e.lo;
        end

        // Reset in the middle of a MULT aborts it.
        @(negedge clk);
        MDUOp = OP_MULT; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        UseMD_D = 1'b1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        chk("abort_stall", 32'(Stall), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        UseMD_D = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_busy", 32'(Busy), 32'd0);
        chk("post_hi", HI, 32'd0);
        chk("post_lo", LO, 32'd0);

        run_op("first_after_rst", OP_MULT, 32'd3, 32'd4, '{hi: 32'd0, lo: 32'd12, lat: 5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
